// File: rtl/ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ctr_pkg
//  Purpose : Shared types and defaults for the retirement pair aligner.
//            Defines the retirement record carried from each lock-step core
//            copy, its flattened width REC, and default sizing parameters.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package ctr_pkg;

  // Field order fixes the packed layout; instr occupies the MSBs.
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg_rs1;
    logic [31:0] reg_rs2;
    logic [31:0] reg_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_r_data;
    logic [3:0]  mem_r_mask;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_w_mask;
    logic [31:0] new_pc;
  } retire_rec_t;

  localparam int REC             = $bits(retire_rec_t);
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/retire_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : retire_fifo
//  Purpose : Single-side record FIFO for the pair aligner. Pure storage: it
//            trusts its parent to never push when full without a pop, and to
//            never pop when empty. Head is read combinationally.
//  Ports   : clk_i, rst_ni  clock, async active-low reset
//            push, pop      write at tail / advance head this edge
//            flush          synchronous clear of pointers and count
//            din, dout      record in at tail, record out at head
//            count          occupancy, log2(DEPTH)+1 bits
//  Revision: 1.0  initial release
// ============================================================================
module retire_fifo
  import ctr_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  retire_rec_t            din,
  output retire_rec_t            dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  retire_rec_t          r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_ptr_w:0]     r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + c_ptr_w'(1);
      if (pop)  r_head <= r_head + c_ptr_w'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid. When full
  // with a simultaneous pop, head == tail: the old head is read out this
  // cycle while the new record overwrites that slot at the edge.
  always_ff @(posedge clk_i) begin
    if (push && !flush) r_mem[r_tail] <= din;
  end

  assign dout  = r_mem[r_head];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/retire_pair_aligner.sv
`default_nettype none
// ============================================================================
//  Module  : retire_pair_aligner
//  Purpose : Buffers retirement records from two lock-step core copies that
//            may retire the same instruction in different cycles, and
//            releases one aligned pair per cycle as a one-cycle retire_o
//            pulse. All outputs are registered on posedge clk_i.
//  Config  : STALL_TIMEOUT_EN - when defined, a stall counter flags desync_o
//            if one side holds data for TIMEOUT edges while the other is
//            empty. When undefined, desync_o is constant 0.
//  Ports   : clk_i, rst_ni          clock, async active-low reset
//            flush_i                sync clear of both FIFOs (flags kept)
//            valid_1_i, rec_1_i     copy 1 retirement strobe and record
//            valid_2_i, rec_2_i     copy 2 retirement strobe and record
//            retire_o               aligned pair valid, one cycle per pair
//            rec_1_o, rec_2_o       aligned records (held while retire_o=0)
//            pair_cnt_o             pairs released since reset, wraps
//            overflow_o             sticky: a push was dropped on full FIFO
//            desync_o               sticky stall-timeout flag
//  Revision: 1.0  initial release
// ============================================================================
module retire_pair_aligner
  import ctr_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_1_i,
  input  retire_rec_t rec_1_i,
  input  logic        valid_2_i,
  input  retire_rec_t rec_2_i,
  output logic        retire_o,
  output retire_rec_t rec_1_o,
  output retire_rec_t rec_2_o,
  output logic [31:0] pair_cnt_o,
  output logic        overflow_o,
  output logic        desync_o
);

  localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [c_cnt_w-1:0] w_cnt_1;
  logic [c_cnt_w-1:0] w_cnt_2;
  retire_rec_t        w_head_1;
  retire_rec_t        w_head_2;
  logic               w_pop;
  logic               w_full_1;
  logic               w_full_2;
  logic               w_push_1;
  logic               w_push_2;
  logic               w_drop;

  logic               r_retire;
  retire_rec_t        r_rec_1;
  retire_rec_t        r_rec_2;
  logic [31:0]        r_pair_cnt;
  logic               r_overflow;

  // Pop decision uses pre-edge occupancy only, so a record pushed at edge N
  // can leave no earlier than edge N+1 (no bypass path).
  assign w_pop    = (w_cnt_1 != '0) && (w_cnt_2 != '0) && !flush_i;
  assign w_full_1 = (w_cnt_1 == c_depth);
  assign w_full_2 = (w_cnt_2 == c_depth);

  // A full side may still accept a push when the same edge pops a pair.
  assign w_push_1 = valid_1_i && !flush_i && (!w_full_1 || w_pop);
  assign w_push_2 = valid_2_i && !flush_i && (!w_full_2 || w_pop);

  // Pushes ignored due to flush are not drops.
  assign w_drop   = !flush_i && !w_pop &&
                    ((valid_1_i && w_full_1) || (valid_2_i && w_full_2));

  retire_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (w_push_1),
    .pop    (w_pop),
    .flush  (flush_i),
    .din    (rec_1_i),
    .dout   (w_head_1),
    .count  (w_cnt_1)
  );

  retire_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (w_push_2),
    .pop    (w_pop),
    .flush  (flush_i),
    .din    (rec_2_i),
    .dout   (w_head_2),
    .count  (w_cnt_2)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_retire   <= 1'b0;
      r_rec_1    <= '0;
      r_rec_2    <= '0;
      r_pair_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_retire <= w_pop;
      if (w_pop) begin
        r_rec_1    <= w_head_1;
        r_rec_2    <= w_head_2;
        r_pair_cnt <= r_pair_cnt + 32'd1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign retire_o   = r_retire;
  assign rec_1_o    = r_rec_1;
  assign rec_2_o    = r_rec_2;
  assign pair_cnt_o = r_pair_cnt;
  assign overflow_o = r_overflow;

`ifdef STALL_TIMEOUT_EN
  localparam int                   c_stall_w = $clog2(TIMEOUT + 1);
  localparam logic [c_stall_w-1:0] c_timeout = c_stall_w'(TIMEOUT);

  logic                 w_one_side;
  logic [c_stall_w-1:0] r_stall;
  logic                 r_desync;

  assign w_one_side = (w_cnt_1 != '0) != (w_cnt_2 != '0);

  // Counter saturates at TIMEOUT; the flag is raised on the edge where the
  // counter reaches TIMEOUT and stays set until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall  <= '0;
      r_desync <= 1'b0;
    end else if (flush_i || w_pop || !w_one_side) begin
      r_stall <= '0;
    end else begin
      if (r_stall < c_timeout) r_stall <= r_stall + c_stall_w'(1);
      if (r_stall >= c_timeout - c_stall_w'(1)) r_desync <= 1'b1;
    end
  end

  assign desync_o = r_desync;
`else
  localparam int c_unused_timeout = TIMEOUT;

  assign desync_o = 1'b0;
`endif

endmodule
`default_nettype wire
